rs232_tx_arb: RTL and testbench

Round-robin arbiter that shares the single rs232_send3 transmitter between several byte-stream requesters. Each requester presents packets (bytes with a last flag). The arbiter locks a grant for a whole packet and forwards bytes through one registered output stage onto the transmitter's valid/ready input. It sits between the on-chip debug sources and rs232_send3, in the 133 MHz OSCH clock domain.

---
 rtl/rs232_pkg.sv | 11 +
 rtl/rr_pick.sv | 24 ++
 rtl/rs232_tx_arb.sv | 109 ++++++++++
 tb/tb_rs232_tx_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared encodings for the rs232 transmit-side arbiter: FSM states and fixed byte values.
package rs232_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_BODY   = 2'd2;

    localparam logic [3:0] HEADER_TAG = 4'hA;
    localparam logic [7:0] IDLE_BYTE  = 8'hFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or after i_ptr, wrapping at N-1.
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_ptr,
    output logic          o_found,
    output logic [GW-1:0] o_idx
);

    // Walk offsets from far to near so the nearest requester is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_found = 1'b1;
                o_idx   = GW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arb.sv
// Round-robin, packet-locked arbiter feeding rs232_send3 through one registered output stage.
// Define RS232_TX_ARB_HEADER_EN to prefix each packet with {4'hA, grantee index}.
module rs232_tx_arb
    import rs232_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    // Handshakes: a beat moves on a rising edge where valid && ready; valid never waits on ready.
    logic [1:0]    r_state;
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] r_grant;
    logic [7:0]    r_out_data;
    logic          r_out_valid;

    logic          w_free;
    logic          w_found;
    logic [GW-1:0] w_idx;
    logic          w_accept;
    logic [7:0]    w_byte;
    logic          w_last;
    logic [GW-1:0] w_next_ptr;

    rr_pick #(.N(NUM_REQ), .GW(GW)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_free     = !r_out_valid || out_ready;
    assign w_byte     = req_data[{r_grant, 3'b000} +: 8];
    assign w_last     = req_last[r_grant];
    assign w_accept   = (r_state == ST_BODY) && req_valid[r_grant] && w_free;
    assign w_next_ptr = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);

    always_comb begin
        req_ready = '0;
        if (r_state == ST_BODY) begin
            req_ready[r_grant] = w_free;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_out_data  <= IDLE_BYTE;
            r_out_valid <= 1'b0;
        end else begin
            // Drain first; a load in the same cycle below overrides it.
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_idx;
`ifdef RS232_TX_ARB_HEADER_EN
                        r_state <= ST_HEADER;
`else
                        r_state <= ST_BODY;
`endif
                    end
                end
`ifdef RS232_TX_ARB_HEADER_EN
                ST_HEADER: begin
                    if (w_free) begin
                        r_out_data  <= {HEADER_TAG, 4'(r_grant)};
                        r_out_valid <= 1'b1;
                        r_state     <= ST_BODY;
                    end
                end
`endif
                ST_BODY: begin
                    if (w_accept) begin
                        r_out_data  <= w_byte;
                        r_out_valid <= 1'b1;
                        if (w_last) begin
                            r_ptr   <= w_next_ptr;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Bench for rs232_tx_arb: packet sources per requester, expected-byte queue, output monitor.
module tb_rs232_tx_arb;

    localparam int N  = 4;
    localparam int N3 = 3;
`ifdef RS232_TX_ARB_HEADER_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [N*8-1:0]   req_data = '0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [1:0]       grant_id;

    logic [N3*8-1:0]  req_data3 = '0;
    logic [N3-1:0]    req_valid3 = '0;
    logic [N3-1:0]    req_last3 = '0;
    logic [N3-1:0]    req_ready3;
    logic [7:0]       out_data3;
    logic             out_valid3;
    logic             out_ready3 = 1'b1;
    logic             busy3;
    logic [1:0]       grant_id3;

    rs232_tx_arb #(.NUM_REQ(N)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    rs232_tx_arb #(.NUM_REQ(N3)) dut3 (
        .clock     (clock),
        .resetn    (resetn),
        .req_data  (req_data3),
        .req_valid (req_valid3),
        .req_last  (req_last3),
        .req_ready (req_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .busy      (busy3),
        .grant_id  (grant_id3)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp3_q[$];
    int         stamp_q[$];

    logic [8:0] src_mem [N][32];
    int         src_rd [N];
    int         src_wr [N];
    logic [8:0] src3_mem [N3][8];
    int         src3_rd [N3];
    int         src3_wr [N3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_src(input int i, input logic [7:0] d, input logic l);
        src_mem[i][src_wr[i] % 32] = {l, d};
        src_wr[i]++;
    endtask

    task automatic push_src3(input int i, input logic [7:0] d, input logic l);
        src3_mem[i][src3_wr[i] % 8] = {l, d};
        src3_wr[i]++;
    endtask

    task automatic expect_hdr(input int id);
        if (H != 0) exp_q.push_back(8'hA0 | 8'(id));
    endtask

    task automatic expect_hdr3(input int id);
        if (H != 0) exp3_q.push_back(8'hA0 | 8'(id));
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        for (int i = 0; i < N3; i++) begin
            src3_rd[i] = 0;
            src3_wr[i] = 0;
        end
        exp_q.delete();
        exp3_q.delete();
        stamp_q.delete();
        step(2);
        resetn = 1'b1;
        step(1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || exp3_q.size() != 0) && n < 300) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: %0d bytes still pending, required 0", name,
                     exp_q.size() + exp3_q.size());
        end
        step(2);
    endtask

    // Sources: head-of-queue byte offered while non-empty; pop on a sampled handshake.
    logic [N-1:0]  fire;
    logic [N3-1:0] fire3;
    always begin
        @(negedge clock);
        fire  = req_valid & req_ready;
        fire3 = req_valid3 & req_ready3;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
            req_valid[i]         = (src_rd[i] < src_wr[i]);
            req_data[i*8 +: 8]   = src_mem[i][src_rd[i] % 32][7:0];
            req_last[i]          = src_mem[i][src_rd[i] % 32][8];
        end
        for (int i = 0; i < N3; i++) begin
            if (fire3[i] && src3_rd[i] < src3_wr[i]) src3_rd[i]++;
            req_valid3[i]        = (src3_rd[i] < src3_wr[i]);
            req_data3[i*8 +: 8]  = src3_mem[i][src3_rd[i] % 8][7:0];
            req_last3[i]         = src3_mem[i][src3_rd[i] % 8][8];
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clock) begin
        if (resetn) begin
            check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected no byte (t=%0t)", out_data, $time);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        stamp_q.push_back(cyc);
                    end
                end
            end
            if (out_valid3) begin
                if (exp3_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out3: got %0h expected no byte (t=%0t)", out_data3, $time);
                end else begin
                    check("out_data3", out_data3, exp3_q[0]);
                    if (out_ready3) void'(exp3_q.pop_front());
                end
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        int c0;
        int n;
        logic [3:0] pat;

        // reset values during and after reset
        step(1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'hFF);
        check("rst_req_ready", req_ready, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        do_reset();
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_out_data", out_data, 8'hFF);
        check("post_rst_req_ready", req_ready, 4'h0);
        check("post_rst_busy", busy, 1'b0);

        // single requester 1: back-to-back bytes, one arbitration cycle
        out_ready = 1'b1;
        c0 = cyc;
        push_src(1, 8'h11, 1'b0);
        push_src(1, 8'h22, 1'b0);
        push_src(1, 8'h33, 1'b1);
        expect_hdr(1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        wait_drain("single");
        check("single_count", stamp_q.size(), 3 + H);
        if (stamp_q.size() == 3 + H) begin
            check("single_lat", stamp_q[H], c0 + 3 + H);
            check("single_b1", stamp_q[H + 1], c0 + 4 + H);
            check("single_b2", stamp_q[H + 2], c0 + 5 + H);
        end
        check("single_grant", grant_id, 2'd1);
        // ptr is now 2: requester 2 wins over requester 0
        push_src(0, 8'h01, 1'b1);
        push_src(2, 8'h02, 1'b1);
        expect_hdr(2);
        exp_q.push_back(8'h02);
        expect_hdr(0);
        exp_q.push_back(8'h01);
        wait_drain("ptr_after");
        check("ptr_after_grant", grant_id, 2'd0);

        // all four requesters, two 2-byte packets each
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                push_src(i, 8'(16 * i), 1'b0);
                push_src(i, 8'(16 * i + 1), 1'b1);
                expect_hdr(i);
                exp_q.push_back(8'(16 * i));
                exp_q.push_back(8'(16 * i + 1));
            end
        end
        wait_drain("rr4");
        check("rr4_count", stamp_q.size(), 8 * (2 + H));
        if (stamp_q.size() == 8 * (2 + H))
            check("rr4_span", stamp_q[stamp_q.size() - 1] - stamp_q[0], 7 * (3 + H) + 1 + H);
        check("rr4_grant", grant_id, 2'd3);
        check("rr4_idle", busy, 1'b0);

        // backpressure 1,0,0,1 during a packet
        do_reset();
        out_ready = 1'b1;
        pat = 4'b1001;
        push_src(0, 8'h31, 1'b0);
        push_src(0, 8'h32, 1'b0);
        push_src(0, 8'h33, 1'b0);
        push_src(0, 8'h34, 1'b1);
        expect_hdr(0);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h34);
        step(2);
        for (int k = 0; k < 12; k++) begin
            out_ready = pat[k % 4];
            step(1);
        end
        out_ready = 1'b1;
        wait_drain("bp");
        check("bp_count", stamp_q.size(), 4 + H);

        // grantee 2 goes quiet mid-packet while requester 3 waits
        do_reset();
        out_ready = 1'b1;
        push_src(2, 8'h41, 1'b0);
        push_src(2, 8'h42, 1'b0);
        push_src(3, 8'h51, 1'b1);
        expect_hdr(2);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        expect_hdr(3);
        exp_q.push_back(8'h51);
        n = 0;
        while (src_rd[2] < 2 && n < 50) begin
            step(1);
            n++;
        end
        check("gap_reach", 32'(src_rd[2]), 32'd2);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("gap_ready3", req_ready[3], 1'b0);
            check("gap_grant", grant_id, 2'd2);
            check("gap_busy", busy, 1'b1);
        end
        push_src(2, 8'h43, 1'b1);
        wait_drain("gap");

        // NUM_REQ=3: non-power-of-two wrap of ptr from 2 back to 0
        do_reset();
        push_src3(1, 8'h71, 1'b1);
        expect_hdr3(1);
        exp3_q.push_back(8'h71);
        wait_drain("n3_a");
        push_src3(2, 8'h55, 1'b1);
        expect_hdr3(2);
        exp3_q.push_back(8'h55);
        wait_drain("n3_b");
        check("n3_grant2", grant_id3, 2'd2);
        push_src3(1, 8'h91, 1'b1);
        push_src3(2, 8'h92, 1'b1);
        expect_hdr3(1);
        exp3_q.push_back(8'h91);
        expect_hdr3(2);
        exp3_q.push_back(8'h92);
        wait_drain("n3_c");
        check("n3_grant_last", grant_id3, 2'd2);

        // reset asserted mid-packet while the output is stalled
        do_reset();
        out_ready = 1'b0;
        push_src(1, 8'h61, 1'b0);
        push_src(1, 8'h62, 1'b0);
        push_src(1, 8'h63, 1'b1);
        expect_hdr(1);
        exp_q.push_back(8'h61);
        step(6);
        check("mid_valid", out_valid, 1'b1);
        check("mid_busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", req_ready, 4'h0);
        check("mid_rst_data", out_data, 8'hFF);
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        exp_q.delete();
        step(2);
        resetn    = 1'b1;
        out_ready = 1'b1;
        step(6);
        check("after_trunc_valid", out_valid, 1'b0);
        check("after_trunc_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
